// File: rtl/param_reorder_buffer.sv
// Parameterised in-order-commit reorder buffer with multi-channel writeback.
// Define ROB_WB_BYPASS_EN to let the rd_* lookup ports see same-cycle writebacks.
module param_reorder_buffer #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NUM_WB = 2,
   localparam int unsigned TAG_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [1:0]               alloc_kind,
   input  logic [4:0]               alloc_rd,
   input  logic [XLEN-1:0]          alloc_pc,
   output logic [TAG_W-1:0]         alloc_tag,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*XLEN-1:0]   wb_data,
   input  logic [NUM_WB*XLEN-1:0]   wb_aux,
   input  logic [NUM_WB-1:0]        wb_mispredict,
   input  logic [2*TAG_W-1:0]       rd_tag,
   output logic [1:0]               rd_ready,
   output logic [2*XLEN-1:0]        rd_data,
   output logic                     commit_valid,
   output logic [4:0]               commit_rd,
   output logic [XLEN-1:0]          commit_data,
   output logic                     st_req,
   output logic [XLEN-1:0]          st_addr,
   output logic [XLEN-1:0]          st_data,
   input  logic                     st_ack,
   output logic                     flush,
   output logic [XLEN-1:0]          flush_pc,
   output logic                     halt,
   output logic [TAG_W:0]           count
);

   typedef enum logic [1:0] {
      K_REG    = 2'd0,
      K_STORE  = 2'd1,
      K_BRANCH = 2'd2,
      K_HALT   = 2'd3
   } kind_e;

   localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

   kind_e            kind_q [DEPTH];
   logic [4:0]       rd_q   [DEPTH];
   logic [XLEN-1:0]  pc_q   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [XLEN-1:0]  aux_q  [DEPTH];
   logic [DEPTH-1:0] valid_q, ready_q, misp_q;
   logic [TAG_W-1:0] head_q, tail_q;

   logic alloc_fire, retire, do_commit, do_flush, do_halt, start_store;

   assign alloc_tag   = tail_q;
   assign alloc_ready = (count < DEPTH_C) && !flush && !halt;
   assign alloc_fire  = alloc_valid && alloc_ready;

   // Commit decisions use registered ready only, so a same-cycle writeback
   // to the head entry naturally delays its commit by one cycle.
   always_comb begin
      retire      = 1'b0;
      do_commit   = 1'b0;
      do_flush    = 1'b0;
      do_halt     = 1'b0;
      start_store = 1'b0;
      if (!halt && valid_q[head_q] && ready_q[head_q]) begin
         unique case (kind_q[head_q])
            K_REG: begin
               do_commit = 1'b1;
               retire    = 1'b1;
            end
            K_STORE: begin
               if (st_req) retire = st_ack;
               else        start_store = 1'b1;
            end
            K_BRANCH: begin
               if (misp_q[head_q]) do_flush = 1'b1;
               else                retire   = 1'b1;
            end
            K_HALT: do_halt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            kind_q[i] <= K_REG;
            rd_q[i]   <= '0;
            pc_q[i]   <= '0;
            data_q[i] <= '0;
            aux_q[i]  <= '0;
         end
         valid_q      <= '0;
         ready_q      <= '0;
         misp_q       <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_data  <= '0;
         st_req       <= 1'b0;
         st_addr      <= '0;
         st_data      <= '0;
         flush        <= 1'b0;
         flush_pc     <= '0;
         halt         <= 1'b0;
      end else begin
         commit_valid <= do_commit;
         flush        <= do_flush;
         if (do_commit) begin
            commit_rd   <= rd_q[head_q];
            commit_data <= data_q[head_q];
         end
         if (start_store) begin
            st_req  <= 1'b1;
            st_addr <= aux_q[head_q];
            st_data <= data_q[head_q];
         end else if (st_req && st_ack) begin
            st_req <= 1'b0;
         end
         if (do_flush) flush_pc <= aux_q[head_q];
         if (do_halt)  halt     <= 1'b1;

         // Highest channel first so the lowest channel's write lands last.
         for (int unsigned k = NUM_WB; k > 0; k--) begin
            if (wb_valid[k-1] && valid_q[wb_tag[(k-1)*TAG_W +: TAG_W]]) begin
               ready_q[wb_tag[(k-1)*TAG_W +: TAG_W]] <= 1'b1;
               data_q[wb_tag[(k-1)*TAG_W +: TAG_W]]  <= wb_data[(k-1)*XLEN +: XLEN];
               aux_q[wb_tag[(k-1)*TAG_W +: TAG_W]]   <= wb_aux[(k-1)*XLEN +: XLEN];
               misp_q[wb_tag[(k-1)*TAG_W +: TAG_W]]  <= wb_mispredict[k-1];
            end
         end

         if (alloc_fire) begin
            kind_q[tail_q]  <= kind_e'(alloc_kind);
            rd_q[tail_q]    <= alloc_rd;
            pc_q[tail_q]    <= alloc_pc;
            valid_q[tail_q] <= 1'b1;
            ready_q[tail_q] <= (alloc_kind == K_HALT);
            misp_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + 1'b1;
         end
         if (retire) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         unique case ({alloc_fire, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (do_flush) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count   <= '0;
         end
      end
   end

   always_comb begin
      logic [TAG_W-1:0] lk;
      lk       = '0;
      rd_ready = '0;
      rd_data  = '0;
      for (int unsigned p = 0; p < 2; p++) begin
         lk = rd_tag[p*TAG_W +: TAG_W];
         if (valid_q[lk]) begin
            rd_ready[p]             = ready_q[lk];
            rd_data[p*XLEN +: XLEN] = data_q[lk];
`ifdef ROB_WB_BYPASS_EN
            for (int unsigned k = NUM_WB; k > 0; k--) begin
               if (wb_valid[k-1] && (wb_tag[(k-1)*TAG_W +: TAG_W] == lk)) begin
                  rd_ready[p]             = 1'b1;
                  rd_data[p*XLEN +: XLEN] = wb_data[(k-1)*XLEN +: XLEN];
               end
            end
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_param_reorder_buffer.sv
// Directed self-checking bench for param_reorder_buffer (DEPTH 16, XLEN 32, NUM_WB 2).
module tb_param_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [1:0]  alloc_kind;
   logic [4:0]  alloc_rd;
   logic [31:0] alloc_pc;
   logic [3:0]  alloc_tag;
   logic [1:0]  wb_valid;
   logic [7:0]  wb_tag;
   logic [63:0] wb_data;
   logic [63:0] wb_aux;
   logic [1:0]  wb_mispredict;
   logic [7:0]  rd_tag;
   logic [1:0]  rd_ready;
   logic [63:0] rd_data;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic        st_req;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ack;
   logic        flush;
   logic [31:0] flush_pc;
   logic        halt;
   logic [4:0]  count;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   param_reorder_buffer #(.DEPTH(16), .XLEN(32), .NUM_WB(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
      .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_aux(wb_aux),
      .wb_mispredict(wb_mispredict),
      .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
      .flush(flush), .flush_pc(flush_pc), .halt(halt), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_wb();
      wb_valid      = '0;
      wb_mispredict = '0;
   endtask

   task automatic wb(input int unsigned ch, input logic [3:0] t, input logic [31:0] d,
                     input logic [31:0] a, input logic m);
      wb_valid[ch]           = 1'b1;
      wb_tag[ch*4 +: 4]      = t;
      wb_data[ch*32 +: 32]   = d;
      wb_aux[ch*32 +: 32]    = a;
      wb_mispredict[ch]      = m;
   endtask

   task automatic alloc1(input logic [1:0] k, input logic [4:0] r);
      alloc_valid = 1'b1;
      alloc_kind  = k;
      alloc_rd    = r;
      alloc_pc    = 32'h1000 + 32'(r);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      alloc_valid = 1'b0;
      st_ack = 1'b0;
      clr_wb();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   logic [31:0] wrap_exp [4];
   int unsigned n_seen;

   initial begin
      rst_n = 1'b0; alloc_valid = 1'b0; alloc_kind = '0; alloc_rd = '0; alloc_pc = '0;
      wb_valid = '0; wb_tag = '0; wb_data = '0; wb_aux = '0; wb_mispredict = '0;
      rd_tag = '0; st_ack = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_commit", commit_valid, 0);
      check("rst_st_req", st_req, 0);
      check("rst_flush_halt", {flush, halt}, 0);
      check("rst_flush_pc", flush_pc, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("rel_alloc_ready", alloc_ready, 1);
      check("rel_alloc_tag", alloc_tag, 0);

      // Fill all 16 entries, then commit tag 0
      for (int unsigned i = 0; i < 16; i++) alloc1(2'd0, 5'(i + 1));
      check("full_count", count, 16);
      check("full_ready", alloc_ready, 0);
      check("full_tag", alloc_tag, 0);
      wb(0, 4'd0, 32'h5, 32'h0, 1'b0);
      tick(); clr_wb();
      check("wb_no_early_commit", commit_valid, 0);
      alloc_valid = 1'b1;
      tick();
      alloc_valid = 1'b0;
      check("c0_valid", commit_valid, 1);
      check("c0_data", commit_data, 32'h5);
      check("c0_rd", commit_rd, 1);
      check("c0_count", count, 15);
      check("c0_no_alloc_tag", alloc_tag, 0);

      // Out-of-order writebacks, in-order commits
      wb(0, 4'd2, 32'h22, 32'h0, 1'b0); tick(); clr_wb();
      wb(0, 4'd1, 32'h11, 32'h0, 1'b0); tick(); clr_wb();
      check("ooo_wait", commit_valid, 0);
      tick();
      check("ooo_c1", {commit_valid, 3'b0, commit_rd, commit_data}, {1'b1, 8'd2, 32'h11});
      tick();
      check("ooo_c2", {commit_valid, 3'b0, commit_rd, commit_data}, {1'b1, 8'd3, 32'h22});
      wb(0, 4'd3, 32'hA0, 32'h0, 1'b0);
      wb(1, 4'd3, 32'hB0, 32'h0, 1'b0);
      tick(); clr_wb();
      check("dual_wait", commit_valid, 0);
      tick();
      check("dual_low_wins", commit_data, 32'hA0);
      check("dual_count", count, 12);

      // Lookup ports
      wb(0, 4'd5, 32'h55, 32'h0, 1'b0); tick(); clr_wb();
      rd_tag = {4'd4, 4'd5};
      #1;
      check("rd_ready_pair", rd_ready, 2'b01);
      check("rd_data5", rd_data[31:0], 32'h55);
      rd_tag = {4'd0, 4'd6};
      wb(0, 4'd6, 32'h77, 32'h0, 1'b0);
      #1;
`ifdef ROB_WB_BYPASS_EN
      check("bypass_ready", rd_ready[0], 1);
      check("bypass_data", rd_data[31:0], 32'h77);
`else
      check("bypass_ready", rd_ready[0], 0);
      check("bypass_data", rd_data[31:0], 32'h0);
`endif
      check("rd_invalid", {rd_ready[1], rd_data[63:32]}, 0);
      tick(); clr_wb();

      // Store with delayed ack; early ack ignored
      do_reset();
      alloc1(2'd1, 5'd0);
      st_ack = 1'b1; tick(); st_ack = 1'b0;
      check("st_early_ack", count, 1);
      wb(0, 4'd0, 32'hAB, 32'h100, 1'b0); tick(); clr_wb();
      check("st_not_yet", st_req, 0);
      tick();
      for (int unsigned c = 0; c < 3; c++) begin
         check("st_hold", {st_req, st_addr, st_data}, {1'b1, 32'h100, 32'hAB});
         if (c == 2) st_ack = 1'b1;
         tick();
      end
      st_ack = 1'b0;
      check("st_done", {st_req, count}, 0);
      tick();
      check("st_no_rereq", st_req, 0);

      // Reset during a pending store
      alloc1(2'd1, 5'd0);
      wb(0, 4'd1, 32'hCD, 32'h200, 1'b0); tick(); clr_wb();
      tick();
      check("st2_req", st_req, 1);
      rst_n = 1'b0;
      #1;
      check("st2_rst_drop", {st_req, count}, 0);
      tick(); rst_n = 1'b1; tick();

      // Mispredicted branch followed by 3 entries
      alloc1(2'd2, 5'd0);
      for (int unsigned i = 0; i < 3; i++) alloc1(2'd0, 5'(i + 1));
      check("br_count", count, 4);
      wb(0, 4'd0, 32'h0, 32'h40, 1'b1); tick(); clr_wb();
      alloc_valid = 1'b1; alloc_kind = 2'd0;
      tick();
      alloc_valid = 1'b0;
      check("flush_pulse", {flush, flush_pc}, {1'b1, 32'h40});
      check("flush_state", {count, alloc_tag, alloc_ready}, 0);
      tick();
      check("flush_end", {flush, alloc_ready}, 2'b01);

      // Correctly predicted branch retires silently
      alloc1(2'd2, 5'd0);
      wb(1, 4'd0, 32'h0, 32'h80, 1'b0); tick(); clr_wb();
      tick();
      check("br_ok", {flush, commit_valid, count}, 0);

      // Wrap: drain 14 entries, then live entries at tags 14,15,0,1
      do_reset();
      for (int unsigned i = 0; i < 14; i++) alloc1(2'd0, 5'd1);
      for (int unsigned i = 0; i < 7; i++) begin
         wb(0, 4'(2*i), 32'h0, 32'h0, 1'b0);
         wb(1, 4'(2*i + 1), 32'h0, 32'h0, 1'b0);
         tick();
      end
      clr_wb();
      for (int unsigned i = 0; i < 40 && count != 0; i++) tick();
      check("wrap_drain", {count, 3'b0, alloc_tag}, {5'd0, 3'b0, 4'd14});
      for (int unsigned i = 0; i < 4; i++) alloc1(2'd0, 5'(10 + i));
      check("wrap_tail", {count, 3'b0, alloc_tag}, {5'd4, 3'b0, 4'd2});
      wrap_exp[0] = 32'h20E; wrap_exp[1] = 32'h20F; wrap_exp[2] = 32'h200; wrap_exp[3] = 32'h201;
      wb(0, 4'd1, 32'h201, 32'h0, 1'b0); wb(1, 4'd0, 32'h200, 32'h0, 1'b0); tick();
      wb(0, 4'd15, 32'h20F, 32'h0, 1'b0); wb(1, 4'd14, 32'h20E, 32'h0, 1'b0); tick();
      clr_wb();
      n_seen = 0;
      for (int unsigned i = 0; i < 20 && n_seen < 4; i++) begin
         tick();
         if (commit_valid) begin
            check("wrap_order", {commit_rd, commit_data}, {5'(10 + n_seen), wrap_exp[n_seen]});
            n_seen++;
         end
      end
      check("wrap_n", n_seen, 4);

      // Halt: ready at allocation, sticky, blocks everything
      do_reset();
      alloc1(2'd3, 5'd0);
      rd_tag = {4'd0, 4'd0};
      #1;
      check("halt_ready_alloc", rd_ready, 2'b11);
      alloc1(2'd0, 5'd7);
      check("halt_set", {halt, alloc_ready, count}, {1'b1, 1'b0, 5'd2});
      wb(0, 4'd1, 32'h99, 32'h0, 1'b0); tick(); clr_wb();
      tick(); tick();
      check("halt_sticky", {halt, commit_valid, count}, {1'b1, 1'b0, 5'd2});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
